// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
//   Shared definitions for the BeeInvaders display path: 640x480@60 VGA timing
//   constants (in pixels, lines and i_clk cycles), the frame-scheduler state
//   encoding and the client index width.
// ----------------------------------------------------------------------------
package vga_pkg;

    // Horizontal timing, in pixels.
    localparam int unsigned H_VISIBLE  = 640;
    localparam int unsigned H_FRONT    = 16;
    localparam int unsigned H_SYNC     = 96;
    localparam int unsigned H_BACK     = 48;
    localparam int unsigned H_TOTAL    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;  // 800

    // Vertical timing, in lines.
    localparam int unsigned V_VISIBLE  = 480;
    localparam int unsigned V_FRONT    = 10;
    localparam int unsigned V_SYNC     = 2;
    localparam int unsigned V_BACK     = 33;
    localparam int unsigned V_TOTAL    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;  // 525

    // 100 MHz i_clk against a 25 MHz pixel clock.
    localparam int unsigned CLK_PER_PX = 4;

    // Lines between the start of vsync and the first active line.
    localparam int unsigned BLANK_LINES = V_SYNC + V_BACK;                      // 35
    localparam int unsigned BLANK_CYC   = BLANK_LINES * H_TOTAL * CLK_PER_PX;   // 112000

    // Client indexing: up to 16 clients, also the width of o_err_id.
    localparam int unsigned MAX_CLIENTS = 16;
    localparam int unsigned IDX_W       = 4;

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWait,
        StCommit
    } sched_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// ----------------------------------------------------------------------------
// sync_edge_detect
//   Registers a signal that is already synchronous to i_clk once and reports
//   its rising and falling edges combinationally in the cycle the new level is
//   presented.
//
// Ports:
//   i_clk   - system clock
//   i_rst   - synchronous, active-high reset (history flop loads RST_VAL)
//   i_sig   - signal to watch
//   o_rise  - previous sample 0, current level 1
//   o_fall  - previous sample 1, current level 0
// ----------------------------------------------------------------------------
module sync_edge_detect #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic sig_q;
    logic sig_d;

    always_comb begin
        sig_d = i_sig;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sig_q <= RST_VAL;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign o_rise = ~sig_q & i_sig;
    assign o_fall = sig_q & ~i_sig;

endmodule

// File: rtl/vblank_scheduler.sv
// ----------------------------------------------------------------------------
// vblank_scheduler
//   Per-frame sequencer for the game-logic clients. A falling edge of vsync
//   (while enabled and idle) starts a frame: each client is launched in turn
//   with a one-cycle start pulse and must answer done before its cycle budget
//   expires and before the active video region begins. If every client
//   finishes, one commit strobe lets the display buffers swap; otherwise the
//   frame is dropped and a sticky overrun flag records the offending client.
//
// Ports:
//   i_clk        - 100 MHz system clock
//   i_rst        - synchronous, active-high reset
//   i_vsync      - VGA vertical sync, active low
//   i_active     - VGA active-pixel flag
//   i_enable     - scheduling enable, looked at only when idle
//   i_done       - per-client completion, only the current client is heard
//   i_clr_err    - clears o_overrun / o_err_id (a same-cycle error wins)
//   o_start      - one-hot single-cycle client start
//   o_busy       - a frame sequence is in progress
//   o_commit     - single-cycle buffer-swap strobe
//   o_overrun    - sticky: client timeout or active video reached first
//   o_err_id     - client index of the most recent error
//   o_frame_cnt  - frames started, wraps
// ----------------------------------------------------------------------------
module vblank_scheduler
    import vga_pkg::*;
#(
    parameter int unsigned NCLIENTS    = 4,
    parameter int unsigned TIMEOUT_CYC = 16384,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_vsync,
    input  logic                i_active,
    input  logic                i_enable,
    input  logic [NCLIENTS-1:0] i_done,
    input  logic                i_clr_err,
    output logic [NCLIENTS-1:0] o_start,
    output logic                o_busy,
    output logic                o_commit,
    output logic                o_overrun,
    output logic [IDX_W-1:0]    o_err_id,
    output logic [CNT_W-1:0]    o_frame_cnt
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCLIENTS - 1);

    // ------------------------------------------------------------------------
    // Edge detection on the timing generator outputs
    // ------------------------------------------------------------------------
    logic vs_fall;
    logic act_rise;
    logic unused_vs_rise;
    logic unused_act_fall;

    // vsync idles high, so its history resets to 1 to avoid a false fall.
    sync_edge_detect #(
        .RST_VAL (1'b1)
    ) u_vsync_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_sig  (i_vsync),
        .o_rise (unused_vs_rise),
        .o_fall (vs_fall)
    );

    sync_edge_detect #(
        .RST_VAL (1'b0)
    ) u_active_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_sig  (i_active),
        .o_rise (act_rise),
        .o_fall (unused_act_fall)
    );

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    sched_state_t       state_q,   state_d;
    logic [IDX_W-1:0]   idx_q,     idx_d;
    logic [TMR_W-1:0]   timer_q,   timer_d;
    logic [CNT_W-1:0]   frame_q,   frame_d;
    logic               overrun_q, overrun_d;
    logic [IDX_W-1:0]   err_id_q,  err_id_d;

    // One-hot decode of the current client index.
    logic [NCLIENTS-1:0] idx_sel;
    logic                done_sel;
    logic                err_set;

    always_comb begin
        idx_sel = '0;
        for (int i = 0; i < NCLIENTS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                idx_sel[i] = 1'b1;
            end
        end
    end

    // Only the client being waited on is listened to.
    assign done_sel = |(i_done & idx_sel);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        timer_d   = timer_q;
        frame_d   = frame_q;
        overrun_d = overrun_q;
        err_id_d  = err_id_q;
        err_set   = 1'b0;

        if (i_clr_err) begin
            overrun_d = 1'b0;
            err_id_d  = '0;
        end

        unique case (state_q)
            StIdle: begin
                if (vs_fall && i_enable) begin
                    idx_d   = '0;
                    frame_d = frame_q + CNT_W'(1);
                    state_d = StLaunch;
                end
            end

            StLaunch: begin
                if (act_rise) begin
                    err_set = 1'b1;
                    state_d = StIdle;
                end else begin
                    timer_d = '0;
                    state_d = StWait;
                end
            end

            StWait: begin
                timer_d = timer_q + TMR_W'(1);
                // Active video beats a same-cycle done: the swap would tear.
                if (act_rise) begin
                    err_set = 1'b1;
                    state_d = StIdle;
                end else if (done_sel) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = StCommit;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = StLaunch;
                    end
                end else if (timer_q == TMR_LAST) begin
                    err_set = 1'b1;
                    state_d = StIdle;
                end
            end

            StCommit: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // A new error overrides a coincident clear.
        if (err_set) begin
            overrun_d = 1'b1;
            err_id_d  = idx_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            timer_q   <= '0;
            frame_q   <= '0;
            overrun_q <= 1'b0;
            err_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            frame_q   <= frame_d;
            overrun_q <= overrun_d;
            err_id_q  <= err_id_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_start     = (state_q == StLaunch) ? idx_sel : '0;
    assign o_busy      = (state_q != StIdle);
    assign o_commit    = (state_q == StCommit);
    assign o_overrun   = overrun_q;
    assign o_err_id    = err_id_q;
    assign o_frame_cnt = frame_q;

endmodule

// File: tb/tb_vblank_scheduler.sv
// ----------------------------------------------------------------------------
// tb_vblank_scheduler
//   Frame-level bench: each frame is described by per-client response delays
//   and optional disturbances (active-video rise, enable drop, second vsync
//   fall, done noise, reset). A transaction model turns that description into
//   the expected list of start / commit / error events with their cycles, and
//   the observed events are compared against it.
// ----------------------------------------------------------------------------
module tb_vblank_scheduler;

    localparam int unsigned NC = 4;
    localparam int unsigned TO = 64;
    localparam int unsigned CW = 4;
    localparam int unsigned IW = $clog2(NC);
    localparam int          NEVER = 1000;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_vsync;
    logic          i_active;
    logic          i_enable;
    logic [NC-1:0] i_done;
    logic          i_clr_err;
    logic [NC-1:0] o_start;
    logic          o_busy;
    logic          o_commit;
    logic          o_overrun;
    logic [3:0]    o_err_id;
    logic [CW-1:0] o_frame_cnt;

    always #5 i_clk = ~i_clk;

    vblank_scheduler #(
        .NCLIENTS    (NC),
        .TIMEOUT_CYC (TO),
        .CNT_W       (CW)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_vsync     (i_vsync),
        .i_active    (i_active),
        .i_enable    (i_enable),
        .i_done      (i_done),
        .i_clr_err   (i_clr_err),
        .o_start     (o_start),
        .o_busy      (o_busy),
        .o_commit    (o_commit),
        .o_overrun   (o_overrun),
        .o_err_id    (o_err_id),
        .o_frame_cnt (o_frame_cnt)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Frame description (set before each run_frame call).
    int cyc = 0;
    int dly [NC];
    bit en;
    bit drop;
    bit dbl;
    bit noise;
    int act_off;
    int rst_off;
    int exp_fc = 0;

    int exp_q[$];
    int obs_q[$];

    // Event encoding: kind 1 = start, 2 = commit, 3 = error.
    function automatic int ev(input int c, input int k, input int i);
        return c * 64 + k * 16 + i;
    endfunction

    task automatic set_defaults();
        for (int i = 0; i < NC; i++) dly[i] = 10;
        en      = 1'b1;
        drop    = 1'b0;
        dbl     = 1'b0;
        noise   = 1'b0;
        act_off = -1;
        rst_off = -1;
    endtask

    task automatic run_frame();
        int t, s, a, last, end_c, vs_end, cur, done_at, rst_at, fc_mid, exp_eid, n;
        bit exp_err, aborted, ovr_prev;
        logic [NC-1:0] nz;
        int keep[$];

        exp_q.delete();
        obs_q.delete();
        t       = cyc + 2;
        a       = (act_off >= 0) ? t + act_off : -100;
        rst_at  = (rst_off >= 0) ? t + rst_off : -100;
        last    = t;
        exp_err = 1'b0;
        exp_eid = 0;
        aborted = 1'b0;

        // Transaction model: walk clients, each owns [start, start+min(d,TO)].
        if (en) begin
            exp_fc = (exp_fc + 1) % (1 << CW);
            s = t + 1;
            for (int i = 0; i < NC; i++) begin
                int  win;
                bit  ok;
                ok  = (dly[i] <= int'(TO));
                win = ok ? s + dly[i] : s + int'(TO);
                exp_q.push_back(ev(s, 1, i));
                last = s;
                if (act_off >= 0 && a >= s && a <= win) begin
                    exp_q.push_back(ev(a + 1, 3, i));
                    exp_err = 1'b1; exp_eid = i; last = a + 1; aborted = 1'b1;
                    break;
                end
                if (!ok) begin
                    exp_q.push_back(ev(s + int'(TO) + 1, 3, i));
                    exp_err = 1'b1; exp_eid = i; last = s + int'(TO) + 1; aborted = 1'b1;
                    break;
                end
                s = s + dly[i] + 1;
            end
            if (!aborted) begin
                exp_q.push_back(ev(s, 2, 0));
                last = s;
            end
        end
        fc_mid = exp_fc;
        end_c  = last + 3;
        if (act_off >= 0 && a + 4 > end_c) end_c = a + 4;
        vs_end = end_c;

        // Reset drops everything after it and zeroes the frame count.
        if (rst_off >= 0) begin
            foreach (exp_q[k]) if (exp_q[k] / 64 <= rst_at) keep.push_back(exp_q[k]);
            exp_q   = keep;
            exp_fc  = 0;
            exp_err = 1'b0;
            exp_eid = 0;
            end_c   = rst_at + 4;
            vs_end  = rst_at + 1;
        end

        cur      = -1;
        done_at  = -1;
        ovr_prev = 1'b0;
        while (cyc <= end_c) begin
            @(negedge i_clk);
            if (o_start != '0) begin
                check_val("start_onehot", $countones(o_start), 1);
                for (int i = 0; i < NC; i++) begin
                    if (o_start[i]) begin
                        cur     = i;
                        done_at = cyc + dly[i];
                        obs_q.push_back(ev(cyc, 1, i));
                    end
                end
            end
            if (o_commit) obs_q.push_back(ev(cyc, 2, 0));
            if (o_overrun && !ovr_prev) obs_q.push_back(ev(cyc, 3, int'(o_err_id)));
            ovr_prev = o_overrun;
            if (en && cyc == t + 1) begin
                check_val("busy_after_vsync", o_busy, 1);
                check_val("frame_cnt_start", o_frame_cnt, fc_mid);
            end
            if (rst_off >= 0 && cyc == rst_at + 1) begin
                check_val("rst_outputs", {o_start, o_busy, o_commit, o_overrun, o_err_id}, 0);
                check_val("rst_frame_cnt", o_frame_cnt, 0);
            end

            i_rst    = (cyc == rst_at);
            i_vsync  = !((cyc >= t && cyc < vs_end) && !(dbl && cyc == t + 1));
            i_enable = en && !(drop && cyc >= t + 2);
            i_active = (act_off >= 0) && cyc >= a && cyc < a + 3;
            nz = noise ? NC'($urandom) : '0;
            if (cur >= 0) begin
                nz[cur[IW-1:0]] = 1'b0;
                if (cyc == done_at) nz[cur[IW-1:0]] = 1'b1;
            end
            i_done = nz;
            @(posedge i_clk);
            cyc++;
        end

        check_val("event_count", obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) check_val("event", obs_q[k], exp_q[k]);
        check_val("busy_end", o_busy, 0);
        check_val("frame_cnt_end", o_frame_cnt, exp_fc);
        check_val("overrun_end", o_overrun, exp_err);
        check_val("err_id_end", o_err_id, exp_eid);

        if (exp_err) begin
            @(negedge i_clk);
            i_clr_err = 1'b1;
            i_done    = '0;
            @(posedge i_clk);
            cyc++;
            @(negedge i_clk);
            check_val("clr_overrun", o_overrun, 0);
            check_val("clr_err_id", o_err_id, 0);
            i_clr_err = 1'b0;
            @(posedge i_clk);
            cyc++;
        end
    endtask

    initial begin
        i_rst     = 1'b1;
        i_vsync   = 1'b1;
        i_active  = 1'b0;
        i_enable  = 1'b0;
        i_done    = '0;
        i_clr_err = 1'b0;
        repeat (3) begin
            @(posedge i_clk);
            cyc++;
        end
        @(negedge i_clk);
        check_val("reset_outputs", {o_start, o_busy, o_commit, o_overrun, o_err_id}, 0);
        check_val("reset_frame_cnt", o_frame_cnt, 0);
        i_rst = 1'b0;
        @(posedge i_clk);
        cyc++;

        // Nominal frame, all clients answer after 10 cycles.
        set_defaults();
        run_frame();

        // Client 2 never answers.
        set_defaults();
        dly[0] = 5; dly[1] = 5; dly[2] = NEVER; dly[3] = 5;
        run_frame();

        // Active video rises in the same cycle client 1 answers.
        set_defaults();
        act_off = 22;
        run_frame();

        // Disabled at the vsync fall.
        set_defaults();
        en = 1'b0;
        run_frame();

        // Enable dropped mid-sequence.
        set_defaults();
        drop = 1'b1;
        dly[0] = 3; dly[1] = 1; dly[2] = 4; dly[3] = 1;
        run_frame();

        // Second vsync fall while busy plus done noise on other clients.
        set_defaults();
        dbl = 1'b1; noise = 1'b1;
        dly[0] = 6; dly[1] = 2; dly[2] = 3; dly[3] = 1;
        run_frame();

        // Budget boundaries: done on the last allowed cycle, then one too late.
        set_defaults();
        dly[0] = TO; dly[1] = 1; dly[2] = TO + 1; dly[3] = 1;
        run_frame();

        // Randomized frames.
        for (int f = 0; f < 30; f++) begin
            set_defaults();
            for (int i = 0; i < NC; i++) begin
                int r;
                r = $urandom_range(0, 19);
                if (r == 0)      dly[i] = NEVER;
                else if (r == 1) dly[i] = TO;
                else if (r == 2) dly[i] = TO + 1;
                else             dly[i] = $urandom_range(1, 12);
            end
            en      = ($urandom_range(0, 7) != 0);
            drop    = $urandom_range(0, 1) == 1;
            dbl     = $urandom_range(0, 1) == 1;
            noise   = $urandom_range(0, 1) == 1;
            act_off = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 60) : -1;
            run_frame();
        end

        // Reset during client 1's wait, then a clean restart.
        set_defaults();
        rst_off = 15;
        run_frame();
        set_defaults();
        for (int i = 0; i < NC; i++) dly[i] = 2;
        run_frame();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Absolute time limit so a stuck run still reports.
    initial begin
        #2000000;
        $display("FAIL timeout: got %0d cycles, expected completion", cyc);
        tests_failed++;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/vblank_scheduler.md
# vblank_scheduler

Frame-update scheduler for BeeInvaders game logic. On each vertical-sync assertion from the 640x480 VGA timing generator, it launches up to NCLIENTS game-logic blocks (player, bees, bullets, score) one at a time with a start/done handshake. When all clients finish inside the vertical blanking window, it issues a single commit strobe so the display double-buffers swap atomically. It sits between the VGA timing generator and the game-object modules, all clocked from the 100 MHz i_clk.

## Interface
Parameters:
- NCLIENTS, 4: number of sequenced clients (1..16).
- TIMEOUT_CYC, 16384: per-client i_clk cycle budget before timeout (≥2).
- CNT_W, 16: frame counter width.

Ports:
- i_clk  in  1  100 MHz system clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_vsync  in  1  VGA vertical sync, active low, synchronous to i_clk.
- i_active  in  1  VGA active-pixel flag, synchronous to i_clk.
- i_enable  in  1  scheduling enable; sampled only in IDLE.
- i_done  in  NCLIENTS  per-client completion pulse/level.
- i_clr_err  in  1  clears o_overrun and o_err_id.
- o_start  out  NCLIENTS  one-hot, single-cycle start pulse.
- o_busy  out  1  high in LAUNCH, WAIT or COMMIT.
- o_commit  out  1  single-cycle buffer-swap strobe.
- o_overrun  out  1  sticky error: timeout or deadline miss.
- o_err_id  out  4  index of the client that caused the last error.
- o_frame_cnt  out  CNT_W  frames started, wraps modulo 2^CNT_W.

## Operation
- Edge detection: i_vsync and i_active are each registered once. vs_fall = prev_vsync & ~i_vsync. act_rise = ~prev_active & i_active.
- States: IDLE, LAUNCH, WAIT, COMMIT.
- IDLE: on vs_fall with i_enable=1, set idx=0, increment o_frame_cnt, and go to LAUNCH. vs_fall with i_enable=0 is ignored.
- LAUNCH: drive o_start[idx]=1 for exactly this cycle, clear the timer, go to WAIT.
- WAIT: the timer increments each cycle. Priority, highest first:
  1. act_rise: set o_overrun, o_err_id=idx, go to IDLE with no commit.
  2. i_done[idx]=1: if idx==NCLIENTS-1 go to COMMIT, else idx+1 and go to LAUNCH.
  3. timer==TIMEOUT_CYC-1: set o_overrun, o_err_id=idx, go to IDLE with no commit.
- An act_rise seen during LAUNCH also aborts as in WAIT.
- COMMIT: o_commit=1 for one cycle, then go to IDLE.
- i_done bits other than idx, and any i_done outside WAIT, are ignored.
- vs_fall outside IDLE is ignored; no re-trigger and no counter increment.
- i_enable deasserted mid-sequence: the current frame completes normally.
- i_clr_err clears o_overrun and o_err_id. If it coincides with a new error, the new error wins.
- Reset values: state IDLE, idx 0, timer 0, every output 0, edge registers 1 (vsync) and 0 (active). Reset mid-sequence aborts immediately with no commit.

## Timing
- i_vsync sampled low at edge t (high at t-1): vs_fall true in cycle t, o_start[0] high in cycle t+1, o_busy high from t+1.
- i_done[idx] sampled at edge k: o_start[idx+1] high in cycle k+1, or o_commit high in cycle k+1 for the last client.
- Minimum frame sequence: 2·NCLIENTS+1 cycles from the first o_start to o_commit, with all clients answering done in the cycle after their start.
- Timeout: no done within TIMEOUT_CYC cycles of o_start gives o_overrun high in cycle start+TIMEOUT_CYC+1.
- Blanking budget: vsync-start to active-start is 35 lines × 800 px × 4 clk = 112000 cycles. NCLIENTS·TIMEOUT_CYC ≤ 112000 is recommended.
- Single-cycle guarantee: o_start and o_commit are never high in adjacent cycles for the same event.

## Structure
- Shared package vga_pkg holds:
  - VGA timing constants (H total 800, V total 525, front porch / sync / back porch values, BLANK_CYC=112000).
  - The state enum sched_state_t.
  - Client index width.
- Sub-module sync_edge_detect (one flop plus rise/fall outputs) is instantiated twice, for vsync and active.
- The timer, index counter and FSM stay in vblank_scheduler.

## Test plan
- NCLIENTS=4. Clients answer done 10 cycles after start. One vsync fall gives o_start pulses 0,1,2,3 spaced 11 cycles apart, then one o_commit; o_frame_cnt goes 0→1 and o_overrun stays 0.
- Client 2 never answers, TIMEOUT_CYC=64. Expect o_overrun=1, o_err_id=2, o_start[3] never asserted, no o_commit. i_clr_err then clears both outputs.
- i_active rises while client 1 is in WAIT, with i_done[1] in the same cycle. Expect abort: o_overrun=1, o_err_id=1, no o_commit.
- i_enable=0 at vsync fall: no o_start and o_frame_cnt unchanged. i_enable dropped after o_start[0]: the sequence still commits.
- Spurious i_done[3] during client 0 WAIT, and a second vsync fall while busy: both ignored, sequence order unchanged, o_frame_cnt increments once.
- i_rst asserted during WAIT of client 1: next cycle all outputs 0, state IDLE. The next vsync fall restarts at client 0 with o_frame_cnt=1.
